// File: rtl/hr_io_pkg.sv
// hr_io_pkg
// Shared constants for the heart-rate IO port endpoint:
//   - active-low 7-segment patterns {g,f,e,d,c,b,a} for digits 0-9 and blank
//   - number of multiplexed display digits
//   - bit positions inside the IOB status byte and the IOD control byte
//   - status_t: the two sticky status flags reported on IOB
//   - seg_decode(): BCD nibble to active-low segment pattern (>9 blanks)
package hr_io_pkg;

   localparam int NUM_DIGITS     = 4;

   localparam int IOB_VALID_BIT  = 0;
   localparam int IOB_OVF_BIT    = 1;

   localparam int IOD_ACK_BIT    = 0;
   localparam int IOD_ENABLE_BIT = 1;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef struct packed {
      logic ovf;
      logic valid;
   } status_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/pulse_debounce.sv
// pulse_debounce
// Brings the raw asynchronous sensor pulse into the clock domain and filters it.
//   clk, reset  : clock, synchronous active-high reset
//   pulse_in    : raw asynchronous pulse
//   event_o     : one-cycle strobe on each rising edge of the debounced level
// The debounced level only follows the synchronized input after the two have
// differed for DEBOUNCE_CYC consecutive cycles; any shorter disagreement
// restarts the count. The event strobe is registered, so an input that rises
// before edge N and stays high produces event_o high after edge N+1+DEBOUNCE_CYC.
module pulse_debounce #(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic pulse_in,
   output logic event_o
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          deb_q,   deb_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          event_q, event_d;

   always_comb begin
      sync1_d = pulse_in;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      if (sync2_q != deb_q) begin
         // The cycle that completes the run flips the level and rearms.
         if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      event_d = deb_d & ~deb_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
         event_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         event_q <= event_d;
      end
   end

   assign event_o = event_q;

endmodule

// File: rtl/hr_io_port.sv
// hr_io_port
// Peripheral-side endpoint of the data memory's memory-mapped IO ports.
//   CLK, RESET     : clock, synchronous active-high reset
//   PULSE_IN       : raw asynchronous heart-beat pulse
//   IOA (out)      : pulse count of the last completed sample window
//   IOB (out)      : status {6'b0, OVF, VALID}
//   IOC (out)      : live pulse count of the current window (saturates at 255)
//   IOD (in)       : control, bit0 ACK, bit1 ENABLE
//   IOE/IOF (in)   : BCD display digits {d1,d0} / {d3,d2}
//   IOG (in)       : LED pattern
//   SEG/AN (out)   : multiplexed 7-segment drive, both active-low
//   LED (out)      : registered copy of IOG
// Every output comes straight from a flop.
module hr_io_port
   import hr_io_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4,
   parameter int WINDOW_CYC   = 1000,
   parameter int SCAN_CYC     = 250
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       PULSE_IN,
   output logic [7:0] IOA,
   output logic [7:0] IOB,
   output logic [7:0] IOC,
   input  logic [7:0] IOD,
   input  logic [7:0] IOE,
   input  logic [7:0] IOF,
   input  logic [7:0] IOG,
   output logic [6:0] SEG,
   output logic [3:0] AN,
   output logic [7:0] LED
);

   localparam int WIN_W  = $clog2(WINDOW_CYC);
   localparam int SCAN_W = $clog2(SCAN_CYC + 1);

   // ---------------------------------------------------------------------
   // Pulse input path
   // ---------------------------------------------------------------------
   logic pulse_event;

   pulse_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .clk      (CLK),
      .reset    (RESET),
      .pulse_in (PULSE_IN),
      .event_o  (pulse_event)
   );

   // ---------------------------------------------------------------------
   // Sample window and CPU handshake
   //
   // VALID/ACK handshake: at the end of every enabled window the count is
   // latched into IOA and VALID rises. The CPU consumes the sample and
   // acknowledges with a 0->1 edge on IOD[ACK]; the edge clears VALID and
   // OVF on the following clock. A level held high acknowledges only once.
   // If a window ends while VALID is still set, the unread sample is lost
   // and OVF is raised. When an ACK edge lands on the same cycle as the end
   // of a window, the fresh sample wins: VALID=1, OVF=0.
   // ---------------------------------------------------------------------
   logic [WIN_W-1:0] win_q,      win_d;
   logic [7:0]       ioc_q,      ioc_d;
   logic [7:0]       ioa_q,      ioa_d;
   status_t          status_q,   status_d;
   logic             ack_prev_q, ack_prev_d;

   logic       enable;
   logic       ack_rise;
   logic       win_term;
   logic [7:0] count_inc;

   always_comb begin
      enable     = IOD[IOD_ENABLE_BIT];
      ack_rise   = IOD[IOD_ACK_BIT] & ~ack_prev_q;
      win_term   = enable && (win_q == WIN_W'(WINDOW_CYC - 1));
      count_inc  = (ioc_q == 8'hFF) ? 8'hFF : ioc_q + {7'd0, pulse_event};

      ack_prev_d = IOD[IOD_ACK_BIT];
      win_d      = win_q;
      ioc_d      = ioc_q;
      ioa_d      = ioa_q;
      status_d   = status_q;

      // Holding the window at 0 while disabled makes re-enable start fresh.
      if (!enable) begin
         win_d = '0;
         ioc_d = '0;
      end else if (win_term) begin
         win_d = '0;
         ioc_d = '0;
         ioa_d = count_inc;
      end else begin
         win_d = win_q + 1'b1;
         ioc_d = count_inc;
      end

      if (ack_rise) begin
         status_d = '0;
      end
      if (win_term) begin
         status_d.valid = 1'b1;
         status_d.ovf   = ack_rise ? 1'b0 : (status_q.valid | status_q.ovf);
      end
   end

   // ---------------------------------------------------------------------
   // Display scan and LEDs
   // SEG and AN are both computed from the next digit index so they change
   // on the same edge and no digit shows its neighbour's pattern.
   // ---------------------------------------------------------------------
   logic [SCAN_W-1:0] scan_q, scan_d;
   logic [1:0]        idx_q,  idx_d;
   logic [3:0]        an_q,   an_d;
   logic [6:0]        seg_q,  seg_d;
   logic [7:0]        led_q,  led_d;
   logic [3:0]        nib;

   always_comb begin
      scan_d = scan_q + 1'b1;
      idx_d  = idx_q;
      if (scan_q == SCAN_W'(SCAN_CYC - 1)) begin
         scan_d = '0;
         idx_d  = idx_q + 1'b1;
      end

      case (idx_d)
         2'd0:    nib = IOE[3:0];
         2'd1:    nib = IOE[7:4];
         2'd2:    nib = IOF[3:0];
         default: nib = IOF[7:4];
      endcase

      an_d  = ~(4'b0001 << idx_d);
      seg_d = seg_decode(nib);
      led_d = IOG;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         win_q      <= '0;
         ioc_q      <= '0;
         ioa_q      <= '0;
         status_q   <= '0;
         ack_prev_q <= 1'b0;
         scan_q     <= '0;
         idx_q      <= '0;
         an_q       <= 4'b1110;
         seg_q      <= SEG_BLANK;
         led_q      <= '0;
      end else begin
         win_q      <= win_d;
         ioc_q      <= ioc_d;
         ioa_q      <= ioa_d;
         status_q   <= status_d;
         ack_prev_q <= ack_prev_d;
         scan_q     <= scan_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         led_q      <= led_d;
      end
   end

   logic unused_iod;
   assign unused_iod = ^IOD[7:2];

   assign IOA = ioa_q;
   assign IOB = {6'd0, status_q.ovf, status_q.valid};
   assign IOC = ioc_q;
   assign AN  = an_q;
   assign SEG = seg_q;
   assign LED = led_q;

endmodule

// File: tb/tb_hr_io_port.sv
// tb_hr_io_port
// Directed bench for hr_io_port. dut runs with DEBOUNCE_CYC=4, WINDOW_CYC=100,
// SCAN_CYC=8. dut_sat uses WINDOW_CYC=2000 and DEBOUNCE_CYC=2 so that 300
// pulses of period 6 fit in one window and drive the count into saturation.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_hr_io_port;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       PULSE_IN = 1'b0;
   logic [7:0] IOD = 8'h00;
   logic [7:0] IOE = 8'h00;
   logic [7:0] IOF = 8'h00;
   logic [7:0] IOG = 8'h00;
   logic [7:0] IOA, IOB, IOC, LED;
   logic [6:0] SEG;
   logic [3:0] AN;

   logic       pulse2 = 1'b0;
   logic [7:0] iod2 = 8'h00;
   logic [7:0] ioa2, iob2, ioc2, led2;
   logic [6:0] seg2;
   logic [3:0] an2;

   int checks = 0;
   int errors = 0;

   hr_io_port #(
      .DEBOUNCE_CYC (4),
      .WINDOW_CYC   (100),
      .SCAN_CYC     (8)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .PULSE_IN (PULSE_IN),
      .IOA      (IOA),
      .IOB      (IOB),
      .IOC      (IOC),
      .IOD      (IOD),
      .IOE      (IOE),
      .IOF      (IOF),
      .IOG      (IOG),
      .SEG      (SEG),
      .AN       (AN),
      .LED      (LED)
   );

   hr_io_port #(
      .DEBOUNCE_CYC (2),
      .WINDOW_CYC   (2000),
      .SCAN_CYC     (8)
   ) dut_sat (
      .CLK      (CLK),
      .RESET    (RESET),
      .PULSE_IN (pulse2),
      .IOA      (ioa2),
      .IOB      (iob2),
      .IOC      (ioc2),
      .IOD      (iod2),
      .IOE      (IOE),
      .IOF      (IOF),
      .IOG      (IOG),
      .SEG      (seg2),
      .AN       (an2),
      .LED      (led2)
   );

   // Clock / reset
   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic pulses(input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) begin
         PULSE_IN = 1'b1;
         tick(hi);
         PULSE_IN = 1'b0;
         tick(lo);
      end
   endtask

   // Reset values, with IOG non-zero so LED=0 really comes from reset.
   task automatic test_reset;
      RESET = 1'b1;
      IOG   = 8'hA5;
      IOE   = 8'h42;
      tick(2);
      checks++; if (IOA !== 8'h00) begin errors++; $display("FAIL reset_ioa got %h exp %h", IOA, 8'h00); end
      checks++; if (IOB !== 8'h00) begin errors++; $display("FAIL reset_iob got %h exp %h", IOB, 8'h00); end
      checks++; if (IOC !== 8'h00) begin errors++; $display("FAIL reset_ioc got %h exp %h", IOC, 8'h00); end
      checks++; if (LED !== 8'h00) begin errors++; $display("FAIL reset_led got %h exp %h", LED, 8'h00); end
      checks++; if (AN !== 4'b1110) begin errors++; $display("FAIL reset_an got %b exp %b", AN, 4'b1110); end
      checks++; if (SEG !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp %h", SEG, 7'h7F); end
      RESET = 1'b0;
   endtask

   // Enable, 7 clean pulses, window closes on the 100th edge after enable.
   task automatic test_window;
      IOD = 8'h02;
      pulses(7, 6, 6);
      tick(15);
      checks++; if (IOC !== 8'd7) begin errors++; $display("FAIL win_live got %0d exp %0d", IOC, 7); end
      checks++; if (IOA !== 8'd0) begin errors++; $display("FAIL win_early_ioa got %0d exp %0d", IOA, 0); end
      tick(1);
      checks++; if (IOA !== 8'd7) begin errors++; $display("FAIL win_ioa got %0d exp %0d", IOA, 7); end
      checks++; if (IOB !== 8'h01) begin errors++; $display("FAIL win_iob got %h exp %h", IOB, 8'h01); end
      checks++; if (IOC !== 8'd0) begin errors++; $display("FAIL win_ioc_clr got %0d exp %0d", IOC, 0); end
   endtask

   // Second window with no ACK raises OVF.
   task automatic test_overflow;
      tick(99);
      checks++; if (IOB !== 8'h01) begin errors++; $display("FAIL ovf_pre got %h exp %h", IOB, 8'h01); end
      tick(1);
      checks++; if (IOB !== 8'h03) begin errors++; $display("FAIL ovf_set got %h exp %h", IOB, 8'h03); end
      checks++; if (IOA !== 8'd0) begin errors++; $display("FAIL ovf_ioa got %0d exp %0d", IOA, 0); end
   endtask

   // ACK edge clears status; held ACK does not re-ack the next sample.
   task automatic test_ack;
      IOD = 8'h03;
      tick(1);
      checks++; if (IOB !== 8'h00) begin errors++; $display("FAIL ack_clr got %h exp %h", IOB, 8'h00); end
      tick(98);
      checks++; if (IOB !== 8'h00) begin errors++; $display("FAIL ack_hold_pre got %h exp %h", IOB, 8'h00); end
      tick(1);
      checks++; if (IOB !== 8'h01) begin errors++; $display("FAIL ack_held got %h exp %h", IOB, 8'h01); end
   endtask

   // ACK edge on the terminal-count cycle while VALID is set.
   task automatic test_ack_terminal;
      IOD = 8'h02;
      pulses(3, 6, 6);
      tick(63);
      checks++; if (IOB !== 8'h01) begin errors++; $display("FAIL ackterm_pre got %h exp %h", IOB, 8'h01); end
      checks++; if (IOC !== 8'd3) begin errors++; $display("FAIL ackterm_live got %0d exp %0d", IOC, 3); end
      IOD = 8'h03;
      tick(1);
      checks++; if (IOB !== 8'h01) begin errors++; $display("FAIL ackterm_iob got %h exp %h", IOB, 8'h01); end
      checks++; if (IOA !== 8'd3) begin errors++; $display("FAIL ackterm_ioa got %0d exp %0d", IOA, 3); end
   endtask

   // 2-cycle glitches never pass the 4-cycle debounce.
   task automatic test_glitch;
      IOD = 8'h02;
      pulses(5, 2, 4);
      tick(6);
      checks++; if (IOC !== 8'd0) begin errors++; $display("FAIL glitch got %0d exp %0d", IOC, 0); end
   endtask

   // Input rises before edge N: count visible after edge N+6, not before.
   task automatic test_single_pulse;
      PULSE_IN = 1'b1;
      tick(6);
      checks++; if (IOC !== 8'd0) begin errors++; $display("FAIL single_early got %0d exp %0d", IOC, 0); end
      tick(1);
      checks++; if (IOC !== 8'd1) begin errors++; $display("FAIL single_lat got %0d exp %0d", IOC, 1); end
      PULSE_IN = 1'b0;
      tick(6);
   endtask

   // Reset mid-window with IOC=3 and earlier sample/status/LED non-zero.
   task automatic test_reset_mid;
      pulses(2, 6, 6);
      tick(6);
      checks++; if (IOC !== 8'd3) begin errors++; $display("FAIL rmid_pre got %0d exp %0d", IOC, 3); end
      RESET = 1'b1;
      tick(1);
      checks++; if (IOA !== 8'h00) begin errors++; $display("FAIL rmid_ioa got %h exp %h", IOA, 8'h00); end
      checks++; if (IOB !== 8'h00) begin errors++; $display("FAIL rmid_iob got %h exp %h", IOB, 8'h00); end
      checks++; if (IOC !== 8'h00) begin errors++; $display("FAIL rmid_ioc got %h exp %h", IOC, 8'h00); end
      checks++; if (LED !== 8'h00) begin errors++; $display("FAIL rmid_led got %h exp %h", LED, 8'h00); end
      checks++; if (AN !== 4'b1110) begin errors++; $display("FAIL rmid_an got %b exp %b", AN, 4'b1110); end
      checks++; if (SEG !== 7'h7F) begin errors++; $display("FAIL rmid_seg got %h exp %h", SEG, 7'h7F); end
      RESET = 1'b0;
   endtask

   // Digit scan: "2","4",blank,"9", 8 cycles per digit, wrap to digit 0.
   task automatic test_display;
      IOD = 8'h00;
      IOE = 8'h42;
      IOF = 8'h9A;
      RESET = 1'b1;
      tick(1);
      RESET = 1'b0;
      tick(1);
      checks++; if (AN !== 4'b1110 || SEG !== 7'h24) begin errors++; $display("FAIL disp_d0 got %b/%h exp %b/%h", AN, SEG, 4'b1110, 7'h24); end
      tick(6);
      checks++; if (AN !== 4'b1110) begin errors++; $display("FAIL disp_hold got %b exp %b", AN, 4'b1110); end
      tick(1);
      checks++; if (AN !== 4'b1101 || SEG !== 7'h19) begin errors++; $display("FAIL disp_d1 got %b/%h exp %b/%h", AN, SEG, 4'b1101, 7'h19); end
      tick(8);
      checks++; if (AN !== 4'b1011 || SEG !== 7'h7F) begin errors++; $display("FAIL disp_d2 got %b/%h exp %b/%h", AN, SEG, 4'b1011, 7'h7F); end
      tick(8);
      checks++; if (AN !== 4'b0111 || SEG !== 7'h10) begin errors++; $display("FAIL disp_d3 got %b/%h exp %b/%h", AN, SEG, 4'b0111, 7'h10); end
      tick(8);
      checks++; if (AN !== 4'b1110 || SEG !== 7'h24) begin errors++; $display("FAIL disp_wrap got %b/%h exp %b/%h", AN, SEG, 4'b1110, 7'h24); end
   endtask

   task automatic test_led;
      IOG = 8'h3C;
      tick(1);
      checks++; if (LED !== 8'h3C) begin errors++; $display("FAIL led_3c got %h exp %h", LED, 8'h3C); end
      IOG = 8'hA5;
      tick(1);
      checks++; if (LED !== 8'hA5) begin errors++; $display("FAIL led_a5 got %h exp %h", LED, 8'hA5); end
   endtask

   // 300 pulses in one 2000-cycle window: live count and sample stop at 255.
   task automatic test_saturation;
      iod2 = 8'h02;
      for (int i = 0; i < 300; i++) begin
         pulse2 = 1'b1;
         tick(3);
         pulse2 = 1'b0;
         tick(3);
      end
      tick(199);
      checks++; if (ioc2 !== 8'd255) begin errors++; $display("FAIL sat_live got %0d exp %0d", ioc2, 255); end
      checks++; if (ioa2 !== 8'd0) begin errors++; $display("FAIL sat_early_ioa got %0d exp %0d", ioa2, 0); end
      tick(1);
      checks++; if (ioa2 !== 8'd255) begin errors++; $display("FAIL sat_ioa got %0d exp %0d", ioa2, 255); end
      checks++; if (iob2 !== 8'h01) begin errors++; $display("FAIL sat_iob got %h exp %h", iob2, 8'h01); end
      checks++; if (ioc2 !== 8'd0) begin errors++; $display("FAIL sat_ioc_clr got %0d exp %0d", ioc2, 0); end
   endtask

   initial begin
      #1;
      test_reset();
      test_window();
      test_overflow();
      test_ack();
      test_ack_terminal();
      test_glitch();
      test_single_pulse();
      test_reset_mid();
      test_display();
      test_led();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
